mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 132 +++++++++++++
 tb/tb_mem_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-port word memory behind a request/valid handshake with a programmable
// response latency and an out-of-range error flag.
module mem_responder #(
  parameter int unsigned ADR_WIDTH = 10,
  parameter logic [31:0] BASE_ADR  = 32'h0000_0000,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        CLK,
  input  logic        RES_N,
  input  logic        MEM_REQ,
  input  logic        MEM_WRITE_ENABLE,
  input  logic [31:0] MEM_ADR,
  input  logic [31:0] MEM_WRITE,
  input  logic [3:0]  MEM_BE,
  output logic        MEM_VALID,
  output logic [31:0] MEM_READ,
  output logic        MEM_ERR
);

  localparam int unsigned DEPTH    = 2 ** ADR_WIDTH;
  localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [31:0] rdat_q, rdat_d;

  logic [31:0] mem [DEPTH];

  logic [31:0]          cmd_adr, cmd_wdat, offset;
  logic [3:0]           cmd_be;
  logic                 cmd_we, in_range, commit;
  logic [ADR_WIDTH-1:0] word_idx;

  // With zero latency the access completes on the capture edge itself, so the
  // live inputs stand in for the not-yet-captured copy while in IDLE.
  always_comb begin
    cmd_adr  = (state_q == IDLE) ? MEM_ADR : adr_q;
    cmd_wdat = (state_q == IDLE) ? MEM_WRITE : wdat_q;
    cmd_be   = (state_q == IDLE) ? MEM_BE : be_q;
    cmd_we   = (state_q == IDLE) ? MEM_WRITE_ENABLE : we_q;
    offset   = cmd_adr - BASE_ADR;
    in_range = (cmd_adr >= BASE_ADR) && ((offset >> (ADR_WIDTH + 2)) == 32'd0);
    word_idx = offset[ADR_WIDTH+1:2];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    be_d    = be_q;
    we_d    = we_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (MEM_REQ) begin
          adr_d  = MEM_ADR;
          wdat_d = MEM_WRITE;
          be_d   = MEM_BE;
          we_d   = MEM_WRITE_ENABLE;
          if (LATENCY > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = RESP;
            commit  = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    valid_d = commit;
    err_d   = commit && !in_range;
    rdat_d  = (commit && in_range && !cmd_we) ? mem[word_idx] : 32'd0;
  end

  // Control and response registers
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
    end
  end

  // Captured request payload
  always_ff @(posedge CLK) begin
    adr_q  <= adr_d;
    wdat_q <= wdat_d;
    be_q   <= be_d;
    we_q   <= we_d;
  end

  // Storage array; contents survive reset
  always_ff @(posedge CLK) begin
    if (commit && in_range && cmd_we) begin
      for (int i = 0; i < 4; i++) begin
        if (cmd_be[i]) mem[word_idx][8*i +: 8] <= cmd_wdat[8*i +: 8];
      end
    end
  end

  assign MEM_VALID = valid_q;
  assign MEM_READ  = rdat_q;
  assign MEM_ERR   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (latency 0, 1, 3) driven through a
// scoreboard of expected read data / error flags.
module tb_mem_responder;

  logic             CLK = 1'b0;
  logic             RES_N;
  logic [2:0]       req, we, vld, err;
  logic [2:0][31:0] adr, wd, rd;
  logic [2:0][3:0]  be;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [3][1024];
  int          checks = 0;
  int          errors = 0;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder #(
      .ADR_WIDTH(10),
      .BASE_ADR (32'h0000_0000),
      .LATENCY  ((g == 0) ? 0 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .CLK             (CLK),
      .RES_N           (RES_N),
      .MEM_REQ         (req[g]),
      .MEM_WRITE_ENABLE(we[g]),
      .MEM_ADR         (adr[g]),
      .MEM_WRITE       (wd[g]),
      .MEM_BE          (be[g]),
      .MEM_VALID       (vld[g]),
      .MEM_READ        (rd[g]),
      .MEM_ERR         (err[g])
    );
  end

  // Drive a request onto instance i and push the expected response.
  task automatic drive(input int i, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    exp_t e;
    req[i] = 1'b1; we[i] = w; adr[i] = a; wd[i] = d; be[i] = b;
    e.err = (a >= 32'h0000_1000);
    e.rd  = 32'd0;
    if (!e.err) begin
      if (w) begin
        for (int k = 0; k < 4; k++) if (b[k]) mdl[i][a[11:2]][8*k +: 8] = d[8*k +: 8];
      end else begin
        e.rd = mdl[i][a[11:2]];
      end
    end
    sb.push_back(e);
  endtask

  // Wait (bounded) for VALID on instance i, sample it and pop the expectation.
  task automatic collect(input int i, input bit keep, output int n,
                         output logic [31:0] r, output logic e_o, output exp_t x);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!vld[i] && n < 40);
    r   = rd[i];
    e_o = err[i];
    if (!vld[i]) n = -1;
    if (!keep) req[i] = 1'b0;
    if (sb.size() > 0) x = sb.pop_front();
    else x = '1;
  endtask

  task automatic test_reset();
    RES_N = 1'b0;
    req = '0; we = '0; adr = '0; wd = '0; be = '0;
    repeat (3) @(negedge CLK);
    checks++; if (vld !== 3'b000) begin errors++; $display("FAIL rst_valid got %b want 000", vld); end
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL rst_err got %b want 000", err); end
    checks++; if (rd !== '0) begin errors++; $display("FAIL rst_read got %h want 0", rd); end
    RES_N = 1'b1;
  endtask

  task automatic test_write_read();
    int n; logic [31:0] r; logic e; exp_t x;
    @(negedge CLK); drive(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    collect(1, 1'b0, n, r, e, x);
    checks++; if (n !== 2) begin errors++; $display("FAIL wr_latency got %0d want 2", n); end
    checks++; if (r !== x.rd || e !== x.err) begin errors++; $display("FAIL wr_resp got %h/%b want %h/%b", r, e, x.rd, x.err); end
    @(negedge CLK); drive(1, 1'b0, 32'h10, 32'h0, 4'h0);
    collect(1, 1'b0, n, r, e, x);
    checks++; if (n !== 2) begin errors++; $display("FAIL rd_latency got %0d want 2", n); end
    checks++; if (r !== 32'hDEADBEEF || r !== x.rd) begin errors++; $display("FAIL rd_data got %h want DEADBEEF", r); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL rd_err got %b want 0", e); end
  endtask

  task automatic test_byte_enable();
    int n; logic [31:0] r; logic e; exp_t x;
    @(negedge CLK); drive(1, 1'b1, 32'h10, 32'h0000AA00, 4'b0010);
    collect(1, 1'b0, n, r, e, x);
    checks++; if (n !== 2 || r !== 32'd0) begin errors++; $display("FAIL be_wr got n=%0d rd=%h want n=2 rd=0", n, r); end
    @(negedge CLK); drive(1, 1'b0, 32'h11, 32'h0, 4'b0001);
    collect(1, 1'b0, n, r, e, x);
    checks++; if (r !== 32'hDEADAAEF || r !== x.rd) begin errors++; $display("FAIL be_merge got %h want DEADAAEF", r); end
    @(negedge CLK); drive(1, 1'b1, 32'h10, 32'h12345678, 4'b0000);
    collect(1, 1'b0, n, r, e, x);
    checks++; if (n !== 2 || e !== 1'b0) begin errors++; $display("FAIL be_zero_done got n=%0d err=%b want n=2 err=0", n, e); end
    @(negedge CLK); drive(1, 1'b0, 32'h10, 32'h0, 4'h0);
    collect(1, 1'b0, n, r, e, x);
    checks++; if (r !== 32'hDEADAAEF || r !== x.rd) begin errors++; $display("FAIL be_zero_keep got %h want DEADAAEF", r); end
  endtask

  task automatic test_back_to_back();
    int n; logic [31:0] r; logic e; exp_t x;
    @(negedge CLK); drive(0, 1'b1, 32'h20, 32'h11112222, 4'hF);
    collect(0, 1'b0, n, r, e, x);
    checks++; if (n !== 1) begin errors++; $display("FAIL lat0_wr_latency got %0d want 1", n); end
    @(negedge CLK); drive(0, 1'b1, 32'h24, 32'h33334444, 4'hF);
    collect(0, 1'b0, n, r, e, x);
    @(negedge CLK); drive(0, 1'b0, 32'h20, 32'h0, 4'h0);
    collect(0, 1'b1, n, r, e, x);
    checks++; if (n !== 1 || r !== 32'h11112222 || r !== x.rd) begin errors++; $display("FAIL b2b_first got n=%0d rd=%h want n=1 rd=11112222", n, r); end
    drive(0, 1'b0, 32'h24, 32'h0, 4'h0);
    @(negedge CLK);
    checks++; if (vld[0] !== 1'b0) begin errors++; $display("FAIL b2b_gap got valid=%b want 0", vld[0]); end
    collect(0, 1'b0, n, r, e, x);
    checks++; if (n !== 1 || r !== 32'h33334444 || r !== x.rd) begin errors++; $display("FAIL b2b_second got n=%0d rd=%h want n=1 rd=33334444", n, r); end
  endtask

  task automatic test_out_of_range();
    int n; logic [31:0] r; logic e; exp_t x;
    @(negedge CLK); drive(1, 1'b1, 32'h0, 32'h01234567, 4'hF);
    collect(1, 1'b0, n, r, e, x);
    @(negedge CLK); drive(1, 1'b1, 32'h1000, 32'hCAFEF00D, 4'hF);
    collect(1, 1'b0, n, r, e, x);
    checks++; if (n !== 2 || e !== 1'b1 || r !== 32'd0 || e !== x.err) begin errors++; $display("FAIL oor_wr got n=%0d err=%b rd=%h want n=2 err=1 rd=0", n, e, r); end
    @(negedge CLK); drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
    collect(1, 1'b0, n, r, e, x);
    checks++; if (r !== 32'h01234567 || r !== x.rd || e !== 1'b0) begin errors++; $display("FAIL oor_word0 got %h/%b want 01234567/0", r, e); end
    @(negedge CLK); drive(1, 1'b0, 32'h1000, 32'h0, 4'hF);
    collect(1, 1'b0, n, r, e, x);
    checks++; if (e !== 1'b1 || r !== 32'd0) begin errors++; $display("FAIL oor_rd got %h/%b want 00000000/1", r, e); end
  endtask

  task automatic test_input_change();
    int n; logic [31:0] r; logic e; exp_t x;
    @(negedge CLK); drive(2, 1'b1, 32'h8, 32'h0A0B0C0D, 4'hF);
    collect(2, 1'b0, n, r, e, x);
    checks++; if (n !== 4) begin errors++; $display("FAIL lat3_latency got %0d want 4", n); end
    @(negedge CLK); drive(2, 1'b1, 32'h30, 32'h55555555, 4'hF);
    @(negedge CLK);
    req[2] = 1'b0; adr[2] = 32'h8; wd[2] = 32'hFFFFFFFF; be[2] = 4'h0; we[2] = 1'b0;
    collect(2, 1'b0, n, r, e, x);
    checks++; if (n !== 3 || r !== 32'd0) begin errors++; $display("FAIL hold_wr got n=%0d rd=%h want n=3 rd=0", n, r); end
    @(negedge CLK); drive(2, 1'b0, 32'h30, 32'h0, 4'h0);
    collect(2, 1'b0, n, r, e, x);
    checks++; if (r !== 32'h55555555 || r !== x.rd) begin errors++; $display("FAIL hold_rd30 got %h want 55555555", r); end
    @(negedge CLK); drive(2, 1'b0, 32'h8, 32'h0, 4'h0);
    collect(2, 1'b0, n, r, e, x);
    checks++; if (r !== 32'h0A0B0C0D || r !== x.rd) begin errors++; $display("FAIL hold_rd8 got %h want 0A0B0C0D", r); end
  endtask

  task automatic test_reset_resp();
    int n; logic [31:0] r; logic e; exp_t x;
    @(negedge CLK); drive(1, 1'b0, 32'h10, 32'h0, 4'hF);
    collect(1, 1'b0, n, r, e, x);
    checks++; if (r !== 32'hDEADAAEF) begin errors++; $display("FAIL resp_data got %h want DEADAAEF", r); end
    RES_N = 1'b0;
    #1;
    checks++; if (vld[1] !== 1'b0 || rd[1] !== 32'd0) begin errors++; $display("FAIL async_rst got valid=%b rd=%h want 0/0", vld[1], rd[1]); end
    @(negedge CLK); RES_N = 1'b1;
  endtask

  task automatic test_reset_wait();
    int n; int seen; logic [31:0] r; logic e; exp_t x;
    @(negedge CLK);
    req[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'h8; wd[2] = 32'h99999999; be[2] = 4'hF;
    @(negedge CLK);
    @(negedge CLK);
    RES_N = 1'b0; req[2] = 1'b0;
    #1;
    checks++; if (vld !== 3'b000 || err !== 3'b000 || rd !== '0) begin errors++; $display("FAIL wait_rst got valid=%b err=%b want 000/000", vld, err); end
    seen = 0;
    repeat (6) begin @(negedge CLK); if (vld[2]) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL wait_rst_pulse got %0d pulses want 0", seen); end
    RES_N = 1'b1;
    drive(2, 1'b0, 32'h8, 32'h0, 4'h0);
    collect(2, 1'b0, n, r, e, x);
    checks++; if (n !== 4) begin errors++; $display("FAIL post_rst_accept got %0d want 4", n); end
    checks++; if (r !== 32'h0A0B0C0D || r !== x.rd) begin errors++; $display("FAIL wait_rst_old got %h want 0A0B0C0D", r); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_back_to_back();
    test_out_of_range();
    test_input_change();
    test_reset_resp();
    test_reset_wait();
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
